// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port RAM between IF and LS requesters with bounded IF starvation
// Define ARB_PERF_CNT_EN to add the if_stall_cnt/ls_stall_cnt stall-cycle counters.
module imem_dmem_arbiter #(
    parameter int MEM_AW = 10,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       if_stall_cnt,
    output logic [31:0]       ls_stall_cnt
`endif
);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
    typedef enum logic [1:0] {R_NONE, R_IF, R_LSR, R_LSW} resp_t;
    resp_t      resp_owner;
    logic [3:0] starve_cnt;
    logic       unused;
    assign unused = ^{if_addr[31:MEM_AW+2], if_addr[1:0], ls_addr[31:MEM_AW+2], ls_addr[1:0]};
    always_comb begin
        if_gnt    = !rst && if_req && (!ls_req || starve_cnt == STARVE_MAX);
        ls_gnt    = !rst && ls_req && !if_gnt;
        mem_en    = if_gnt || ls_gnt;
        mem_we    = (ls_gnt && ls_we) ? ls_be : 4'b0000;
        mem_addr  = if_gnt ? if_addr[MEM_AW+1:2] : ls_gnt ? ls_addr[MEM_AW+1:2] : '0;
        mem_wdata = ls_gnt ? ls_wdata : '0;
        // rst gating discards a response that was still outstanding when reset hit
        if_rvalid = !rst && resp_owner == R_IF;
        ls_rvalid = !rst && (resp_owner == R_LSR || resp_owner == R_LSW);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = (!rst && resp_owner == R_LSR) ? mem_rdata : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            resp_owner <= R_NONE;
        end else begin
            starve_cnt <= (!if_req || if_gnt) ? 4'd0 : (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
            resp_owner <= if_gnt ? R_IF : !ls_gnt ? R_NONE : ls_we ? R_LSW : R_LSR;
        end
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if_stall_cnt <= 32'd0;
            ls_stall_cnt <= 32'd0;
        end else begin
            if_stall_cnt <= if_stall_cnt + 32'(if_req && !if_gnt);
            ls_stall_cnt <= ls_stall_cnt + 32'(ls_req && !ls_gnt);
        end
    end
`endif
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed and randomized checks of imem_dmem_arbiter against a RAM and reference model
module tb_imem_dmem_arbiter;
    localparam int AW = 10;
    localparam int MS = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0;
    logic [3:0] ls_be = 4'h0;
    logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en;
    logic [31:0] if_rdata, ls_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0] mem_we;
    logic [AW-1:0] mem_addr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt, ls_stall_cnt;
`endif
    logic [31:0] ram  [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] refm [0:(1<<AW)-1] = '{default: 32'h0};
    int n_chk = 0;
    int n_fail = 0;

    imem_dmem_arbiter #(.MEM_AW(AW), .MAX_STARVE(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .if_stall_cnt(if_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h40; ls_addr = 32'h44;
        for (int i = 0; i < 2; i++) begin
            tick(); #2;
            n_chk++;
            if ({if_gnt, ls_gnt, mem_en, if_rvalid, ls_rvalid, mem_we} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d got %b want 0", i, {if_gnt, ls_gnt, mem_en, if_rvalid, ls_rvalid, mem_we});
            end
        end
        tick(); rst = 1'b0; #2;
        n_chk++;
        if ({if_gnt, ls_gnt, mem_en, if_rvalid, ls_rvalid} !== 5'b01100) begin
            n_fail++;
            $display("FAIL reset_release got %b want 01100", {if_gnt, ls_gnt, mem_en, if_rvalid, ls_rvalid});
        end
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_ls_write_read();
        tick(); ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; #2;
        n_chk++;
        if ({ls_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 10'd8, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL ls_write_drive got gnt=%b we=%b addr=%0d wd=%h want 1 0011 8 deadbeef", ls_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick(); ls_we = 1'b0; #2;
        n_chk++;
        if ({ls_rvalid, ls_rdata, mem_we, ls_gnt} !== {1'b1, 32'h0, 4'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ls_write_ack got rv=%b rd=%h we=%b gnt=%b want 1 0 0 1", ls_rvalid, ls_rdata, mem_we, ls_gnt);
        end
        tick(); ls_req = 1'b0; #2;
        n_chk++;
        if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL ls_read_data got rv=%b rd=%h want 1 0000beef", ls_rvalid, ls_rdata);
        end
        tick(); ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h10; ls_wdata = 32'h0062_82B3;
        tick(); ls_req = 1'b0; ls_we = 1'b0;
    endtask

    task automatic test_if_only();
        tick(); if_req = 1'b1; if_addr = 32'h10; #2;
        n_chk++;
        if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr} !== {3'b101, 4'b0, 10'd4}) begin
            n_fail++;
            $display("FAIL if_only_drive got gnt=%b/%b en=%b we=%b addr=%0d want 1/0 1 0 4", if_gnt, ls_gnt, mem_en, mem_we, mem_addr);
        end
        tick(); if_req = 1'b0; #2;
        n_chk++;
        if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== {2'b10, 32'h0062_82B3, 32'h0}) begin
            n_fail++;
            $display("FAIL if_only_resp got rv=%b/%b rd=%h/%h want 1/0 006282b3/0", if_rvalid, ls_rvalid, if_rdata, ls_rdata);
        end
    endtask

    task automatic test_contention();
        logic e, p;
        p = 1'b0;
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = 32'h10; ls_addr = 32'h20;
        tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            e = (i % 5 == 4);
            n_chk++;
            if ({if_gnt, ls_gnt} !== {e, !e}) begin
                n_fail++;
                $display("FAIL contention_gnt cycle %0d got %b%b want %b%b", i, if_gnt, ls_gnt, e, !e);
            end
            if (i > 0) begin
                n_chk++;
                if ({if_rvalid, ls_rvalid} !== {p, !p}) begin
                    n_fail++;
                    $display("FAIL contention_rvalid cycle %0d got %b%b want %b%b", i, if_rvalid, ls_rvalid, p, !p);
                end
            end
            p = e;
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0; #2;
        n_chk++;
        if ({if_rvalid, ls_rvalid, if_rdata} !== {2'b10, 32'h0062_82B3}) begin
            n_fail++;
            $display("FAIL contention_last got rv=%b%b rd=%h want 10 006282b3", if_rvalid, ls_rvalid, if_rdata);
        end
`ifdef ARB_PERF_CNT_EN
        n_chk++;
        if ({if_stall_cnt, ls_stall_cnt} !== {32'd8, 32'd2}) begin
            n_fail++;
            $display("FAIL perf_cnt got if=%0d ls=%0d want 8 2", if_stall_cnt, ls_stall_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        tick(); if_req = 1'b1; if_addr = 32'h20; #2;
        n_chk++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_if_gnt got %b%b want 10", if_gnt, ls_gnt);
        end
        tick(); if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; #2;
        n_chk++;
        if ({ls_gnt, if_rvalid, ls_rvalid, if_rdata} !== {3'b110, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL b2b_n1 got gnt=%b rv=%b%b rd=%h want 1 10 0000beef", ls_gnt, if_rvalid, ls_rvalid, if_rdata);
        end
        tick(); ls_req = 1'b0; #2;
        n_chk++;
        if ({if_rvalid, ls_rvalid, ls_rdata, if_rdata} !== {2'b01, 32'h0062_82B3, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_n2 got rv=%b%b rd=%h/%h want 01 006282b3/0", if_rvalid, ls_rvalid, ls_rdata, if_rdata);
        end
    endtask

    task automatic test_wrap();
        tick(); ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'hF000_0026; ls_wdata = 32'h1234_5678; #2;
        n_chk++;
        if (mem_addr !== 10'd9) begin
            n_fail++;
            $display("FAIL wrap_addr got %0d want 9", mem_addr);
        end
        tick(); ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0024;
        tick(); if_req = 1'b0; #2;
        n_chk++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL wrap_read got rv=%b rd=%h want 1 12345678", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_reset_midop();
        tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        tick(); ls_req = 1'b0; rst = 1'b1; #2;
        n_chk++;
        if ({ls_rvalid, ls_rdata} !== 33'b0) begin
            n_fail++;
            $display("FAIL midop_during_rst got rv=%b rd=%h want 0 0", ls_rvalid, ls_rdata);
        end
        tick(); rst = 1'b0; #2;
        n_chk++;
        if ({if_rvalid, ls_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_after_rst got rv=%b%b want 00", if_rvalid, ls_rvalid);
        end
    endtask

    function automatic logic [31:0] raddr();
        return ($urandom & 32'hFFFF_F000) | (32'(16 + $urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic pif, pls, pwe, gi, gl, ev_if, ev_ls;
        logic [31:0] pai, pal, pwd, ed_if, ed_ls;
        logic [3:0] pbe;
        logic [9:0] wi, wl;
        int waited;
        pif = 1'b0; pls = 1'b0; pwe = 1'b0; pai = 0; pal = 0; pwd = 0; pbe = 0;
        gi = 1'b0; gl = 1'b0; ev_if = 1'b0; ev_ls = 1'b0; ed_if = 0; ed_ls = 0; waited = 0;
        if_req = 1'b0; ls_req = 1'b0;
        tick(); tick();
        for (int c = 0; c < 600; c++) begin
            tick();
            if (gi || !pif) begin
                pif = $urandom_range(0, 3) != 0;
                pai = raddr();
            end
            if (gl || !pls) begin
                pls = $urandom_range(0, 3) != 0;
                pwe = $urandom_range(0, 1) == 1;
                pbe = 4'($urandom);
                pal = raddr();
                pwd = $urandom;
            end
            if_req = pif; if_addr = pai; ls_req = pls; ls_we = pwe; ls_be = pbe; ls_addr = pal; ls_wdata = pwd;
            #2;
            gi = pif && (!pls || waited >= MS);
            gl = pls && !gi;
            wi = pai[AW+1:2];
            wl = pal[AW+1:2];
            n_chk++;
            if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
                {gi, gl, gi | gl, (gl && pwe) ? pbe : 4'b0, gi ? wi : gl ? wl : 10'd0, gl ? pwd : 32'h0}) begin
                n_fail++;
                $display("FAIL rnd_drive cycle %0d got gnt=%b%b en=%b we=%b addr=%0d wd=%h want gnt=%b%b", c,
                         if_gnt, ls_gnt, mem_en, mem_we, mem_addr, mem_wdata, gi, gl);
            end
            n_chk++;
            if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== {ev_if, ev_ls, ed_if, ed_ls}) begin
                n_fail++;
                $display("FAIL rnd_resp cycle %0d got rv=%b%b rd=%h/%h want rv=%b%b rd=%h/%h", c,
                         if_rvalid, ls_rvalid, if_rdata, ls_rdata, ev_if, ev_ls, ed_if, ed_ls);
            end
            ev_if = gi;
            ed_if = gi ? refm[wi] : 32'h0;
            ev_ls = gl;
            ed_ls = (gl && !pwe) ? refm[wl] : 32'h0;
            if (gl && pwe)
                for (int b = 0; b < 4; b++)
                    if (pbe[b]) refm[wl][8*b +: 8] = pwd[8*b +: 8];
            waited = (pif && !gi) ? ((waited < MS) ? waited + 1 : waited) : 0;
        end
        tick(); if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ls_write_read();
        test_if_only();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
        test_contention();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch (IF) requester and load/store (LS) requester.
- This is the first step from the single-cycle core toward a unified-memory, stall-capable core.
- Sits between the PC/fetch logic and data-memory access logic on one side and a single RAM macro on the other.
- Per cycle: grants at most one requester, returns read data one cycle later, and bounds IF starvation with a counter.

Parameters:
- MEM_AW, 10, RAM word-address width (RAM holds 2^MEM_AW 32-bit words).
- MAX_STARVE, 4, consecutive denied IF-request cycles after which IF gets priority; range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  IF requests a word read.
- if_addr  input  32  IF byte address; bits [1:0] ignored.
- if_gnt  output  1  IF request accepted this cycle (combinational).
- if_rvalid  output  1  IF read data valid (registered, one cycle after if_gnt).
- if_rdata  output  32  IF read data.
- ls_req  input  1  LS requests an access.
- ls_we  input  1  1 = write, 0 = read.
- ls_be  input  4  byte enables for writes.
- ls_addr  input  32  LS byte address; bits [1:0] ignored.
- ls_wdata  input  32  write data.
- ls_gnt  output  1  LS request accepted this cycle (combinational).
- ls_rvalid  output  1  LS response (read data or write ack), one cycle after ls_gnt.
- ls_rdata  output  32  LS read data.
- mem_en  output  1  RAM access enable.
- mem_we  output  4  RAM byte write enables.
- mem_addr  output  MEM_AW  RAM word address = granted addr[MEM_AW+1:2].
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- While rst=1: if_gnt=0, ls_gnt=0, mem_en=0, mem_we=0, if_rvalid=0, ls_rvalid=0, starve_cnt=0, resp_owner=NONE. Grants are forced low during reset even if requests are high.
- Handshake: requester holds req, addr, we, be and wdata stable until gnt=1. The transfer completes on the gnt cycle. The requester may drop req or issue a new request in the very next cycle (back-to-back allowed).
- Arbitration (combinational, one grant max):
  - only one req high -> grant it.
  - both high and starve_cnt < MAX_STARVE -> grant LS.
  - both high and starve_cnt == MAX_STARVE -> grant IF.
- starve_cnt (4-bit):
  - reset to 0 on any if_gnt, or when if_req=0.
  - increment when if_req=1 and denied.
  - saturate at MAX_STARVE.
- Memory drive:
  - mem_en = if_gnt | ls_gnt.
  - mem_we = (ls_gnt & ls_we) ? ls_be : 4'b0000.
  - mem_addr and mem_wdata come from the granted requester. When idle they are 0.
- Response tracking: register resp_owner (NONE/IF/LS) from the grant each cycle. Next cycle:
  - if_rvalid = (resp_owner==IF).
  - ls_rvalid = (resp_owner==LS).
  - if_rdata = mem_rdata when owner==IF, else 0.
  - ls_rdata = mem_rdata when owner==LS read, else 0. Write acks return ls_rdata=0.
- Latency: fixed 1 cycle from gnt to rvalid. Throughput is one access per cycle.
- Reset mid-operation: an outstanding response is discarded. No rvalid in the cycle after reset deasserts unless a grant occurred in the first non-reset cycle.
- Address bits beyond MEM_AW+1 are ignored (wrap-around within RAM).

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds outputs if_stall_cnt[31:0] and ls_stall_cnt[31:0].
  - Each counts cycles where its req=1 and gnt=0.
  - Reset to 0 by rst; wrap at 2^32.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=ls_req=1 -> all gnt/rvalid/mem_en = 0. First cycle after release: ls_gnt=1, if_gnt=0.
- IF only: if_req=1, if_addr=0x0000_0010 -> same cycle if_gnt=1, mem_addr=4, mem_we=0. Next cycle if_rvalid=1, if_rdata=mem_rdata (e.g. 0x0062_82B3).
- LS write then read: ls_we=1, ls_be=4'b0011, ls_addr=0x20, ls_wdata=0xDEAD_BEEF -> mem_we=4'b0011, mem_addr=8; next cycle ls_rvalid=1, ls_rdata=0. Then a read of 0x20 -> ls_rdata=0x0000_BEEF (model RAM).
- Contention fairness: if_req=ls_req=1 continuously, MAX_STARVE=4 -> grant pattern LS,LS,LS,LS,IF repeating. starve_cnt returns to 0 after the IF grant.
- Back-to-back: IF granted at cycle n, LS at n+1 -> if_rvalid at n+1, ls_rvalid at n+2, never both in one cycle.
- With ARB_PERF_CNT_EN: 10 cycles of contention from reset -> if_stall_cnt=8, ls_stall_cnt=2.
